fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipeline. Owns the program counter, issues requests to
//  instruction memory over a req/ack handshake, and drives toPC/toPCInc/toIR/toValid into the
//  IF/ID pipeline register every cycle. Honours stall from the hazard unit and redirect
//  (branch/jump/R7 write) from later stages. Inserts NOP bubbles when no instruction is available.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  NOP_INSTR  16'hF000  encoding driven on toIR when toValid=0
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset (asserts immediately; releases synchronously to clk)
//  stall        in   1   hazard unit: hold toPC/toPCInc/toIR/toValid and PC
//  redirect     in   1   later stage overrides PC this cycle
//  redirect_pc  in   16  new PC when redirect=1
//  imem_req     out  1   fetch request
//  imem_addr    out  16  fetch address; stable while imem_req=1 and imem_ack=0
//  imem_ack     in   1   imem_data valid this cycle for the outstanding request
//  imem_data    in   16  instruction word
//  toPC         out  16  PC of instruction on toIR
//  toPCInc      out  16  toPC+1
//  toIR         out  16  fetched instruction or NOP_INSTR
//  toValid      out  1   toIR holds a real instruction
// BEHAVIOUR
//  Reset (reset=0): pc=RESET_PC, toPC=0, toPCInc=0, toIR=NOP_INSTR, toValid=0, imem_req=0, state=S_IDLE.
//  States: S_IDLE, S_REQ, S_HOLD, S_DROP.
//  S_IDLE: imem_req=0; next cycle -> S_REQ. Redirect here loads pc=redirect_pc.
//  S_REQ: imem_req=1, imem_addr=pc. Priority per cycle: redirect > ack/stall.
//   - ack & !stall: toIR<=imem_data, toPC<=pc, toPCInc<=pc+1, toValid<=1, pc<=pc+1; stay S_REQ
//     (back-to-back: one instruction per cycle when memory acks every cycle).
//   - ack & stall: outputs held; imem_data captured in skid buffer; -> S_HOLD.
//   - !ack & stall: outputs held. !ack & !stall: toValid<=0, toIR<=NOP_INSTR (bubble).
//  S_HOLD: imem_req=0, outputs held while stall=1; when stall=0: skid -> outputs, toValid<=1,
//   pc<=pc+1, -> S_REQ.
//  Redirect (any state, overrides stall): pc<=redirect_pc; toValid<=0, toIR<=NOP_INSTR.
//   S_REQ with ack same cycle: data discarded -> S_REQ. S_REQ without ack: -> S_DROP.
//   S_HOLD: skid discarded -> S_REQ.
//  S_DROP: imem_req=1, imem_addr=old address (latched) until ack; data discarded; -> S_REQ at
//   redirect_pc. A second redirect in S_DROP updates pc, stays S_DROP.
//  Arithmetic: pc+1 is 16-bit modulo; 16'hFFFF -> 16'h0000, no flag.
//  Latency: ack at cycle n -> toIR valid from cycle n+1; IF/ID captures it at end of n+1.
//  Reset mid-request: outstanding request abandoned; memory must tolerate req dropping.
// CONFIGURATION
//  FETCH_STATS_EN defined: adds outputs fetch_count[15:0] (increments when toValid loads 1) and
//   bubble_count[15:0] (increments on each cycle toValid<=0 without stall); both saturate at
//   16'hFFFF, reset to 0. Not defined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Shared header fetch_defs.vh: state encodings S_IDLE..S_DROP, NOP_INSTR default, width 16.
//  One sub-module: fetch_skid_buffer (16-bit data + valid, load/clear/unload) used in S_HOLD.
//  PC and output registers built from existing register16/register1 cells.
// TESTING
//  Reset release, imem_ack every cycle from 0x0000 -> toPC 0,1,2,3 on consecutive cycles,
//   toPCInc=toPC+1, toValid=1 from cycle 2.
//  stall=1 for 3 cycles while ack arrives at pc=0x0005 -> outputs frozen, imem_req=0 in S_HOLD;
//   stall=0 -> toPC=0x0005, toIR=skid data, next request 0x0006.
//  ack delayed 2 cycles at pc=0x0010 -> two cycles toValid=0/toIR=0xF000, imem_addr stable 0x0010.
//  redirect to 0x0100 while request to 0x0020 outstanding -> S_DROP, addr stays 0x0020 until ack,
//   its data never reaches toIR; next request 0x0100.
//  pc=0xFFFF fetched -> toPCInc=0x0000, next imem_addr=0x0000.
//  FETCH_STATS_EN: 4 fetches + 2 bubbles -> fetch_count=4, bubble_count=2; force 0xFFFF, stays.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, state encodings and helpers for the fetch stage
package fetch_stage_pkg;

   localparam int WIDTH = 16;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   localparam logic [WIDTH-1:0] NOP_DEFAULT = 16'hF000;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] value);
      return (value == {WIDTH{1'b1}}) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry holding register for a word acked while the pipe is stalled
module fetch_skid_buffer
   import fetch_stage_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic             unload,
   input  logic [WIDTH-1:0] capture,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (clear || unload) begin
         valid <= 1'b0;
      end else if (load) begin
         data  <= capture;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem req/ack handshake, IF/ID outputs
// Optional FETCH_STATS_EN adds saturating fetch_count / bubble_count outputs.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [WIDTH-1:0] RESET_PC  = 16'h0000,
   parameter logic [WIDTH-1:0] NOP_INSTR = NOP_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_data,
   output logic [WIDTH-1:0] toPC,
   output logic [WIDTH-1:0] toPCInc,
   output logic [WIDTH-1:0] toIR,
   output logic             toValid
`ifdef FETCH_STATS_EN
   ,
   output logic [WIDTH-1:0] fetch_count,
   output logic [WIDTH-1:0] bubble_count
`endif
);

   logic [1:0]       state, state_d;
   logic [WIDTH-1:0] pc, pc_d, pc_inc;
   logic [WIDTH-1:0] drop_addr, drop_addr_d;
   logic [WIDTH-1:0] fetched;
   logic             load_out, load_bubble;
   logic             skid_load, skid_clear, skid_unload;
   logic [WIDTH-1:0] skid_data;
   logic             skid_valid;

   assign pc_inc    = pc + 16'd1;
   assign imem_req  = (state == S_REQ) || (state == S_DROP);
   // An abandoned request keeps its original address on the bus until memory acks it.
   assign imem_addr = (state == S_DROP) ? drop_addr : pc;

   always_comb begin
      state_d     = state;
      pc_d        = pc;
      drop_addr_d = drop_addr;
      fetched     = imem_data;
      load_out    = 1'b0;
      load_bubble = 1'b0;
      skid_load   = 1'b0;
      skid_clear  = 1'b0;
      skid_unload = 1'b0;
      if (redirect) begin
         pc_d        = redirect_pc;
         load_bubble = 1'b1;
         skid_clear  = 1'b1;
         state_d     = S_REQ;
         if (state == S_REQ && !imem_ack) begin
            state_d     = S_DROP;
            drop_addr_d = pc;
         end else if (state == S_DROP && !imem_ack) begin
            state_d = S_DROP;
         end
      end else begin
         case (state)
            S_IDLE: begin
               state_d = S_REQ;
            end
            S_REQ: begin
               if (imem_ack && !stall) begin
                  load_out = 1'b1;
                  pc_d     = pc_inc;
               end else if (imem_ack) begin
                  skid_load = 1'b1;
                  state_d   = S_HOLD;
               end else if (!stall) begin
                  load_bubble = 1'b1;
               end
            end
            S_HOLD: begin
               if (!stall && skid_valid) begin
                  load_out    = 1'b1;
                  fetched     = skid_data;
                  skid_unload = 1'b1;
                  pc_d        = pc_inc;
                  state_d     = S_REQ;
               end
            end
            S_DROP: begin
               if (imem_ack) begin
                  state_d = S_REQ;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         drop_addr <= RESET_PC;
      end else begin
         state     <= state_d;
         pc        <= pc_d;
         drop_addr <= drop_addr_d;
      end
   end

   // toPC/toPCInc keep their last values across bubbles; only toIR/toValid mark the hole.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         toPC    <= '0;
         toPCInc <= '0;
         toIR    <= NOP_INSTR;
         toValid <= 1'b0;
      end else if (load_out) begin
         toPC    <= pc;
         toPCInc <= pc_inc;
         toIR    <= fetched;
         toValid <= 1'b1;
      end else if (load_bubble) begin
         toIR    <= NOP_INSTR;
         toValid <= 1'b0;
      end
   end

   fetch_skid_buffer u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load),
      .clear   (skid_clear),
      .unload  (skid_unload),
      .capture (imem_data),
      .data    (skid_data),
      .valid   (skid_valid)
   );

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count  <= '0;
         bubble_count <= '0;
      end else begin
         if (load_out) begin
            fetch_count <= sat_inc(fetch_count);
         end
         if (load_bubble && !stall) begin
            bubble_count <= sat_inc(bubble_count);
         end
      end
   end
`endif

endmodule
